bexkat2_intunit: RTL and testbench

Parametrised multi-cycle integer unit for the bexkat2 CPU. It executes the `intfunc_t` operation set: MUL, DIV, MOD, MULU, DIVU, MODU, MULX, MULUX, EXT, EXTB, COM and NEG. Unlike the fixed-width single-cycle T_INT path, it uses a radix-2 iterative multiplier/divider of configurable width, a start/done handshake, divide-by-zero reporting and a full-width high product. The control FSM issues an operation from S_INT and waits in S_INT2/S_INT3 until `done_o`.

---
 rtl/bexkat2_intunit_if.sv | 14 +
 rtl/bexkat2_intunit.sv | 117 +++++++++++
 tb/tb_bexkat2_intunit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bexkat2_intunit_if.sv
// bexkat2_intunit_if: start/done handshake, operands and results of the integer unit.
interface bexkat2_intunit_if #(parameter int WIDTH = 32);
    logic             start_i;
    logic [3:0]       func_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] out_o;
    logic [WIDTH-1:0] outx_o;
    logic             dbz_o;
    modport slave (input start_i, func_i, a_i, b_i, output busy_o, done_o, out_o, outx_o, dbz_o);
    modport master (output start_i, func_i, a_i, b_i, input busy_o, done_o, out_o, outx_o, dbz_o);
endinterface

// File: rtl/bexkat2_intunit.sv
// bexkat2_intunit: radix-2 iterative multiply/divide plus unary ops for the bexkat2 CPU.
module bexkat2_intunit #(parameter int WIDTH = 32) (
    input logic clk_i,
    input logic rst_i,
    bexkat2_intunit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
    state_t state_q, state_d;
    logic [3:0] func_q, func_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, lo_q, lo_d;
    logic [WIDTH-1:0] out_q, out_d, outx_q, outx_d;
    logic dbz_q, dbz_d, done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] amag_i, bmag, dsub, quo, rem, ext, extb;
    logic [WIDTH:0] msum, drem;
    logic [2*WIDTH-1:0] prod_c;
    logic dge, sa, sb, b_zero;
    function automatic logic f_mul(input logic [3:0] f);
        return f inside {4'd0, 4'd3, 4'd6, 4'd7};
    endfunction
    function automatic logic f_div(input logic [3:0] f);
        return f inside {4'd1, 4'd2, 4'd4, 4'd5};
    endfunction
    function automatic logic f_sgn(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd6};
    endfunction
    function automatic logic f_mod(input logic [3:0] f);
        return f inside {4'd2, 4'd5};
    endfunction
    // Iterations run on magnitudes; signs are reapplied from the latched raw operands in FIX.
    always_comb begin
        amag_i = (f_sgn(bus.func_i) && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
        sa = f_sgn(func_q) && a_q[WIDTH-1];
        sb = f_sgn(func_q) && b_q[WIDTH-1];
        bmag = sb ? -b_q : b_q;
        b_zero = b_q == '0;
        msum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, bmag} : '0);
        drem = {acc_q, lo_q[WIDTH-1]};
        dge = drem >= {1'b0, bmag};
        dsub = drem[WIDTH-1:0] - bmag;
        prod_c = (sa ^ sb) ? -{acc_q, lo_q} : {acc_q, lo_q};
        quo = (sa ^ sb) ? -lo_q : lo_q;
        rem = sa ? -acc_q : acc_q;
        ext = WIDTH'($signed(a_q[15:0]));
        extb = WIDTH'($signed(a_q[7:0]));
    end
    always_comb begin
        state_d = state_q;
        func_d = func_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        lo_d = lo_q;
        cnt_d = cnt_q;
        out_d = out_q;
        outx_d = outx_q;
        dbz_d = dbz_q;
        done_d = state_q == S_FIX;
        if (state_q == S_IDLE && bus.start_i) begin
            func_d = bus.func_i;
            a_d = bus.a_i;
            b_d = bus.b_i;
            acc_d = '0;
            lo_d = amag_i;
            cnt_d = CW'(WIDTH);
            state_d = (f_mul(bus.func_i) || (f_div(bus.func_i) && bus.b_i != '0)) ? S_RUN : S_FIX;
        end else if (state_q == S_RUN) begin
            acc_d = f_mul(func_q) ? msum[WIDTH:1] : (dge ? dsub : drem[WIDTH-1:0]);
            lo_d = f_mul(func_q) ? {msum[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], dge};
            cnt_d = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? S_FIX : S_RUN;
        end else if (state_q == S_FIX) begin
            out_d = f_mul(func_q) ? prod_c[WIDTH-1:0] :
                    f_div(func_q) ? (b_zero ? (f_mod(func_q) ? a_q : '1) : (f_mod(func_q) ? rem : quo)) :
                    func_q == 4'd8 ? ext :
                    func_q == 4'd9 ? extb :
                    func_q == 4'd10 ? ~a_q :
                    func_q == 4'd11 ? -a_q : '0;
            outx_d = f_mul(func_q) ? prod_c[2*WIDTH-1:WIDTH] : '0;
            dbz_d = f_div(func_q) && b_zero;
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            func_q <= '0;
            a_q <= '0;
            b_q <= '0;
            acc_q <= '0;
            lo_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            outx_q <= '0;
            dbz_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q <= func_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
            lo_q <= lo_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            outx_q <= outx_d;
            dbz_q <= dbz_d;
            done_q <= done_d;
        end
    end
    assign bus.busy_o = state_q != S_IDLE;
    assign bus.done_o = done_q;
    assign bus.out_o = out_q;
    assign bus.outx_o = outx_q;
    assign bus.dbz_o = dbz_q;
endmodule

// File: tb/tb_bexkat2_intunit.sv
// tb_bexkat2_intunit: directed and random ops on 32- and 16-bit units against an arithmetic model.
module tb_bexkat2_intunit;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    bexkat2_intunit_if #(.WIDTH(32)) b32 ();
    bexkat2_intunit_if #(.WIDTH(16)) b16 ();
    bexkat2_intunit #(.WIDTH(32)) u32 (.clk_i(clk), .rst_i(rst), .bus(b32.slave));
    bexkat2_intunit #(.WIDTH(16)) u16 (.clk_i(clk), .rst_i(rst), .bus(b16.slave));

    task automatic chk(input string tag, input int w, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s w=%0d observed=%0h expected=%0h", tag, w, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        if (w == 32) begin
            b32.start_i = s; b32.func_i = f; b32.a_i = a[31:0]; b32.b_i = b[31:0];
        end else begin
            b16.start_i = s; b16.func_i = f; b16.a_i = a[15:0]; b16.b_i = b[15:0];
        end
    endtask

    task automatic rd(input int w, output logic busy, output logic done, output logic [63:0] o,
                      output logic [63:0] x, output logic d);
        if (w == 32) begin
            busy = b32.busy_o; done = b32.done_o; o = {32'b0, b32.out_o}; x = {32'b0, b32.outx_o}; d = b32.dbz_o;
        end else begin
            busy = b16.busy_o; done = b16.done_o; o = {48'b0, b16.out_o}; x = {48'b0, b16.outx_o}; d = b16.dbz_o;
        end
    endtask

    // Plain signed/unsigned integer arithmetic on w-bit values held in 64 bits.
    task automatic model(input int w, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] eo, output logic [63:0] ex, output logic ed, output int lat);
        logic [63:0] m, pu;
        longint sa, sb, p;
        m = (64'd1 << w) - 64'd1;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        eo = 0; ex = 0; ed = 0; lat = 2;
        case (f)
            4'd0, 4'd6: begin p = sa * sb; pu = p; eo = pu & m; ex = (pu >> w) & m; lat = w + 2; end
            4'd3, 4'd7: begin pu = a * b; eo = pu & m; ex = (pu >> w) & m; lat = w + 2; end
            4'd1, 4'd2: if (b == 0) begin ed = 1; eo = (f == 4'd1) ? m : a; end
                        else begin p = (f == 4'd1) ? sa / sb : sa % sb; pu = p; eo = pu & m; lat = w + 2; end
            4'd4, 4'd5: if (b == 0) begin ed = 1; eo = (f == 4'd4) ? m : a; end
                        else begin eo = (f == 4'd4) ? a / b : a % b; lat = w + 2; end
            4'd8: begin p = longint'($signed(a[15:0])); pu = p; eo = pu & m; end
            4'd9: begin p = longint'($signed(a[7:0])); pu = p; eo = pu & m; end
            4'd10: eo = ~a & m;
            4'd11: eo = (-a) & m;
            default: ;
        endcase
    endtask

    // Issues one op in the current cycle; returns just after the done_o edge so the next call starts back-to-back.
    task automatic run_op(input int w, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                          input int glitch, output logic [63:0] go, output logic [63:0] gx, output logic gd);
        logic [63:0] eo, ex;
        logic ed, busy, done;
        int lat, n;
        model(w, f, a, b, eo, ex, ed, lat);
        drive(w, 1'b1, f, a, b);
        n = 0;
        done = 1'b0;
        busy = 1'b0;
        while (!done && n < 80) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) drive(w, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            if (glitch != 0 && n == glitch) drive(w, 1'b1, 4'($urandom_range(0, 11)), {$urandom, $urandom}, 64'd1);
            if (glitch != 0 && n == glitch + 1) drive(w, 1'b0, 4'd0, 64'd0, 64'd0);
            rd(w, busy, done, go, gx, gd);
            if (n == 1) begin
                chk("busy_cycle1", w, 64'(busy), 64'd1);
                chk("done_single_pulse", w, 64'(done), 64'd0);
            end
        end
        chk($sformatf("latency_f%0d", f), w, 64'(n), 64'(lat));
        chk("busy_in_done", w, 64'(busy), 64'd0);
        chk($sformatf("out_f%0d", f), w, go, eo);
        chk($sformatf("outx_f%0d", f), w, gx, ex);
        chk($sformatf("dbz_f%0d", f), w, 64'(gd), 64'(ed));
    endtask

    task automatic rst_test(input int w);
        logic busy, done, d, seen;
        logic [63:0] o, x;
        drive(w, 1'b1, 4'd0, {$urandom, $urandom}, {$urandom, $urandom});
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) drive(w, 1'b0, 4'd0, 64'd0, 64'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(w, busy, done, o, x, d);
        chk("rst_busy", w, 64'(busy), 64'd0);
        chk("rst_done", w, 64'(done), 64'd0);
        chk("rst_out", w, o, 64'd0);
        chk("rst_outx", w, x, 64'd0);
        chk("rst_dbz", w, 64'(d), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            rd(w, busy, done, o, x, d);
            seen = seen | done;
        end
        chk("rst_no_done", w, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] m, go, gx, a, b;
        logic gd, busy, done;
        int widths[2] = '{32, 16};
        rst = 1'b1;
        drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
        drive(16, 1'b0, 4'd0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        foreach (widths[i]) begin
            rd(widths[i], busy, done, go, gx, gd);
            chk("reset_busy", widths[i], 64'(busy), 64'd0);
            chk("reset_done", widths[i], 64'(done), 64'd0);
            chk("reset_out", widths[i], go, 64'd0);
            chk("reset_outx", widths[i], gx, 64'd0);
            chk("reset_dbz", widths[i], 64'(gd), 64'd0);
        end
        rst = 1'b0;
        foreach (widths[i]) begin
            int w;
            w = widths[i];
            m = (64'd1 << w) - 64'd1;
            run_op(w, 4'd6, m - 1, 64'd3, 0, go, gx, gd);
            chk("mulx_lo", w, go, m - 5); chk("mulx_hi", w, gx, m);
            run_op(w, 4'd7, m - 1, 64'd3, 0, go, gx, gd);
            chk("mulux_lo", w, go, m - 5); chk("mulux_hi", w, gx, 64'd2);
            run_op(w, 4'd1, m - 6, 64'd2, 0, go, gx, gd);
            chk("div_neg7_2", w, go, m - 2);
            run_op(w, 4'd2, m - 6, 64'd2, 0, go, gx, gd);
            chk("mod_neg7_2", w, go, m);
            run_op(w, 4'd1, 64'd1 << (w - 1), m, 0, go, gx, gd);
            chk("div_min_m1", w, go, 64'd1 << (w - 1)); chk("div_min_m1_dbz", w, 64'(gd), 64'd0);
            run_op(w, 4'd4, 64'd5, 64'd0, 0, go, gx, gd);
            chk("divu_dbz_out", w, go, m); chk("divu_dbz_flag", w, 64'(gd), 64'd1);
            run_op(w, 4'd5, 64'd5, 64'd0, 0, go, gx, gd);
            chk("modu_dbz_out", w, go, 64'd5); chk("modu_dbz_flag", w, 64'(gd), 64'd1);
            run_op(w, 4'd9, 64'h12345680 & m, 64'd7, 0, go, gx, gd);
            chk("extb", w, go, m - 64'h7F);
            run_op(w, 4'd8, 64'h7FFF, 64'd7, 0, go, gx, gd);
            chk("ext", w, go, 64'h7FFF);
            run_op(w, 4'd11, 64'd1, 64'd7, 0, go, gx, gd);
            chk("neg1", w, go, m);
            run_op(w, 4'd10, 64'd0, 64'd7, 0, go, gx, gd);
            chk("com0", w, go, m);
            run_op(w, 4'd13, m, m, 0, go, gx, gd);
            chk("illegal13", w, go, 64'd0);
            run_op(w, 4'd1, {$urandom, $urandom} & m, ({$urandom, $urandom} & m) | 64'd1, 5, go, gx, gd);
            for (int k = 0; k < 60; k++) begin
                int r;
                r = $urandom_range(0, 9);
                a = (r == 0) ? (64'd1 << (w - 1)) : ({$urandom, $urandom} & m);
                r = $urandom_range(0, 9);
                b = (r == 0) ? 64'd0 : (r == 1) ? m : ({$urandom, $urandom} & m);
                run_op(w, 4'($urandom_range(0, 15)), a, b, 0, go, gx, gd);
            end
            rst_test(w);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
